// File: rtl/mult_share_pkg.sv
// Shared types and widths for the controller that time-shares one seq16x9 multiplier.
package mult_share_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_WAIT   = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam int MX_W            = 16;
  localparam int MY_W            = 9;
  localparam int PROD_W          = 25;
  localparam int DEF_MUL_LATENCY = 20;

  function automatic int next_rr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mult_share_ctrl_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] idx,
  output logic           any
);

  int j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = IDW'(j);
      end
    end
  end

endmodule

// File: rtl/mult_share_ctrl.sv
// Arbitrates NREQ clients onto one seq16x9 multiplier; one operation in flight, tagged response.
// state  | meaning
// IDLE   | arbitrate, grant one requester, latch its operands
// LAUNCH | pulse mul_rst for one cycle, load latency timer
// WAIT   | count down; at terminal count capture the product
// RESP   | hold product/id valid until the consumer accepts
module mult_share_ctrl
  import mult_share_pkg::*;
#(
  parameter int NREQ        = 4,
  parameter int MUL_LATENCY = DEF_MUL_LATENCY,
  parameter int IDW         = 2
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*MX_W-1:0]   req_mx,
  input  logic [NREQ*MY_W-1:0]   req_my,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [PROD_W-1:0]      rsp_prod,
  output logic [IDW-1:0]         rsp_id,
  output logic                   mul_rst,
  output logic [MX_W-1:0]        mul_mx,
  output logic [MY_W-1:0]        mul_my,
  input  logic [PROD_W-1:0]      mul_prod,
  output logic                   busy
);

  localparam int CNT_W = $clog2(MUL_LATENCY + 1);

  state_t           state, state_nxt;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   gnt_id;
  logic [CNT_W-1:0] counter;

  logic [NREQ-1:0]  arb_gnt;
  logic [IDW-1:0]   arb_idx;
  logic             arb_any;
  logic [MX_W-1:0]  sel_mx;
  logic [MY_W-1:0]  sel_my;

  logic             take_grant;
  logic             load_cnt;
  logic             cap_rsp;
  logic             rsp_done;

  rr_arbiter #(
    .N   (NREQ),
    .IDW (IDW)
  ) u_arb (
    .req (req_valid),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    sel_mx = '0;
    sel_my = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        sel_mx = req_mx[i*MX_W +: MX_W];
        sel_my = req_my[i*MY_W +: MY_W];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = '0;
    take_grant = 1'b0;
    load_cnt   = 1'b0;
    cap_rsp    = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      ST_IDLE: begin
        // grant is suppressed under reset so no client sees a handshake that is not taken
        if (arb_any && !RESET) begin
          req_ready  = arb_gnt;
          take_grant = 1'b1;
          state_nxt  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        load_cnt  = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (counter == '0) begin
          cap_rsp   = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          rsp_done  = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      rr_ptr    <= '0;
      gnt_id    <= '0;
      counter   <= '0;
      mul_mx    <= '0;
      mul_my    <= '0;
      rsp_valid <= 1'b0;
      rsp_prod  <= '0;
      rsp_id    <= '0;
    end else begin
      if (take_grant) begin
        mul_mx <= sel_mx;
        mul_my <= sel_my;
        gnt_id <= arb_idx;
        rr_ptr <= IDW'(next_rr(int'(arb_idx), NREQ));
      end
      if (load_cnt) begin
        counter <= CNT_W'(MUL_LATENCY - 1);
      end else if (state == ST_WAIT && counter != '0) begin
        counter <= counter - 1'b1;
      end
      if (cap_rsp) begin
        rsp_prod  <= mul_prod;
        rsp_id    <= gnt_id;
        rsp_valid <= 1'b1;
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

  // multiplier restarts from its load states whenever it leaves reset
  assign mul_rst = RESET | (state == ST_LAUNCH);
  assign busy    = (state != ST_IDLE);

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Bench for mult_share_ctrl with a behavioural seq16x9 stand-in and a transaction-level reference model.
module tb_mult_share_ctrl;

  localparam int NREQ = 4;
  localparam int LAT  = 20;
  localparam int IDW  = 2;

  logic            CLK = 1'b0;
  logic            RESET = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ-1:0] req_ready;
  logic [NREQ*16-1:0] req_mx = '0;
  logic [NREQ*9-1:0]  req_my = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [24:0]     rsp_prod;
  logic [IDW-1:0]  rsp_id;
  logic            mul_rst;
  logic [15:0]     mul_mx;
  logic [8:0]      mul_my;
  logic [24:0]     mul_prod;
  logic            busy;

  mult_share_ctrl #(.NREQ(NREQ), .MUL_LATENCY(LAT), .IDW(IDW)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_mx(req_mx), .req_my(req_my),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_prod(rsp_prod), .rsp_id(rsp_id),
    .mul_rst(mul_rst), .mul_mx(mul_mx), .mul_my(mul_my),
    .mul_prod(mul_prod), .busy(busy)
  );

  always #5 CLK = ~CLK;

  // multiplier stand-in: product correct only LAT cycles after reset release, inverted before that
  int pm_cnt = 0;
  logic [24:0] pm_full;
  assign pm_full  = 25'(mul_mx) * 25'(mul_my);
  assign mul_prod = (pm_cnt >= LAT - 1) ? pm_full : ~pm_full;
  always @(posedge CLK) begin
    if (mul_rst) pm_cnt <= 0;
    else if (pm_cnt < 1000) pm_cnt <= pm_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  logic [NREQ-1:0] s_rdy;
  logic s_rv, s_mrst, s_busy;
  logic [24:0] s_prod;
  logic [IDW-1:0] s_id;
  logic [15:0] s_mx;
  logic [8:0] s_my;
  int s_cyc;

  bit m_fly = 0;
  int m_gcyc = 0;
  int m_id = 0;
  int m_ptr = 0;
  logic [24:0] m_prod = '0;
  int e_id;
  bit e_rv;

  int mrst_cnt = 0;
  int rdy_cnt = 0;
  int grant_log[$];
  int rsp_id_log[$];
  logic [24:0] rsp_prod_log[$];

  typedef struct {
    int          id;
    logic [15:0] mx;
    logic [8:0]  my;
    logic [24:0] prod;
  } vec_t;
  vec_t vecs[7];

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic fail_timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out (cycle %0d)", nm, cyc);
  endtask

  task automatic model_check();
    logic [NREQ-1:0] exp_rdy;
    int j;
    e_id = -1;
    e_rv = 0;
    if (RESET) begin
      cmp("rst_req_ready", 32'(s_rdy), 32'(0));
      cmp("rst_mul_rst", 32'(s_mrst), 32'(1));
      return;
    end
    if (!m_fly) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (e_id < 0 && req_valid[j]) e_id = j;
      end
    end
    exp_rdy = '0;
    if (e_id >= 0) exp_rdy[e_id] = 1'b1;
    e_rv = m_fly && (cyc >= m_gcyc + LAT + 2);
    cmp("req_ready", 32'(s_rdy), 32'(exp_rdy));
    cmp("rsp_valid", 32'(s_rv), 32'(e_rv));
    cmp("busy", 32'(s_busy), 32'(m_fly));
    cmp("mul_rst", 32'(s_mrst), 32'(m_fly && cyc == m_gcyc + 1));
    if (e_rv) begin
      cmp("rsp_prod", 32'(s_prod), 32'(m_prod));
      cmp("rsp_id", 32'(s_id), 32'(m_id));
    end
  endtask

  task automatic model_advance();
    if (RESET) begin
      m_fly = 0;
      m_ptr = 0;
    end else if (e_id >= 0) begin
      m_fly  = 1;
      m_gcyc = cyc;
      m_id   = e_id;
      m_prod = 25'(req_mx[e_id*16 +: 16]) * 25'(req_my[e_id*9 +: 9]);
      m_ptr  = (e_id + 1) % NREQ;
    end else if (e_rv && rsp_ready) begin
      m_fly = 0;
    end
  endtask

  task automatic step();
    #1;
    s_rdy = req_ready; s_rv = rsp_valid; s_prod = rsp_prod; s_id = rsp_id;
    s_mrst = mul_rst; s_busy = busy; s_mx = mul_mx; s_my = mul_my; s_cyc = cyc;
    model_check();
    model_advance();
    if (!RESET && s_mrst) mrst_cnt++;
    if (s_rdy != '0) begin
      rdy_cnt++;
      for (int i = 0; i < NREQ; i++) if (s_rdy[i]) grant_log.push_back(i);
    end
    if (!RESET && s_rv && rsp_ready) begin
      rsp_id_log.push_back(int'(s_id));
      rsp_prod_log.push_back(s_prod);
    end
    @(negedge CLK);
    cyc++;
  endtask

  task automatic do_reset(input int n);
    RESET = 1'b1;
    repeat (n) step();
    RESET = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 0;
    req_valid = '0;
    rsp_ready = 1'b1;
    for (int t = 0; t < 80 && !done; t++) begin
      step();
      if (!m_fly && !s_rv) done = 1;
    end
    if (!done) fail_timeout("drain");
  endtask

  task automatic set_ops(input int id, input logic [15:0] mx, input logic [8:0] my);
    req_mx[id*16 +: 16] = mx;
    req_my[id*9 +: 9]   = my;
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int t = 0; t < 40 && g < 0; t++) begin
      step();
      if (s_rdy != '0) g = s_cyc;
    end
  endtask

  task automatic run_single(input int id, input logic [15:0] mx, input logic [8:0] my,
                            input logic [24:0] exp_p);
    int g, r, m0, rd0;
    logic [24:0] p;
    logic [IDW-1:0] pid;
    r = -1; p = '0; pid = '0;
    m0 = mrst_cnt; rd0 = rdy_cnt;
    set_ops(id, mx, my);
    req_valid = '0;
    req_valid[id] = 1'b1;
    rsp_ready = 1'b1;
    wait_grant(g);
    req_valid = '0;
    if (g < 0) begin
      fail_timeout("single_grant");
      return;
    end
    for (int t = 0; t < 40 && r < 0; t++) begin
      step();
      if (s_rv) begin r = s_cyc; p = s_prod; pid = s_id; end
    end
    if (r < 0) begin
      fail_timeout("single_rsp");
      return;
    end
    cmp("tbl_prod", 32'(p), 32'(exp_p));
    cmp("tbl_id", 32'(pid), 32'(id));
    cmp("tbl_latency", 32'(r - g - 1), 32'(LAT + 1));
    cmp("tbl_mul_rst_pulses", 32'(mrst_cnt - m0), 32'(1));
    cmp("tbl_ready_pulses", 32'(rdy_cnt - rd0), 32'(1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int g, g0, r0, bp_bad, gcount;
    int exp_ord[5];
    logic [24:0] cap_p;
    logic [IDW-1:0] cap_id;
    bit seen3;

    vecs[0] = '{1, 16'h1234, 9'h1FF, 25'h02455CC};
    vecs[1] = '{0, 16'hFFFF, 9'h1FF, 25'h1FEFE01};
    vecs[2] = '{0, 16'h0000, 9'h1FF, 25'h0000000};
    vecs[3] = '{2, 16'h0001, 9'h001, 25'h0000001};
    vecs[4] = '{3, 16'hFFFF, 9'h000, 25'h0000000};
    vecs[5] = '{3, 16'h8000, 9'h100, 25'h0800000};
    vecs[6] = '{2, 16'h00FF, 9'h0FF, 25'h000FE01};
    exp_ord = '{0, 1, 2, 3, 0};

    @(negedge CLK);
    req_valid = '1;
    do_reset(3);
    req_valid = '0;
    step();
    cmp("reset_rsp_prod", 32'(s_prod), 32'(0));
    cmp("reset_rsp_id", 32'(s_id), 32'(0));
    cmp("reset_mul_mx", 32'(s_mx), 32'(0));
    cmp("reset_mul_my", 32'(s_my), 32'(0));

    for (int v = 0; v < 7; v++) run_single(vecs[v].id, vecs[v].mx, vecs[v].my, vecs[v].prod);
    drain();

    // all four requesters continuously valid, pointer fresh from reset
    do_reset(2);
    for (int i = 0; i < NREQ; i++) set_ops(i, 16'(i + 1), 9'(i + 2));
    g0 = grant_log.size();
    r0 = rsp_id_log.size();
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int t = 0; t < 200 && grant_log.size() - g0 < 5; t++) step();
    drain();
    if (grant_log.size() - g0 < 5 || rsp_id_log.size() - r0 < 5) fail_timeout("rr_sequence");
    else begin
      for (int k = 0; k < 5; k++) begin
        cmp("rr_grant_order", 32'(grant_log[g0+k]), 32'(exp_ord[k]));
        cmp("rr_rsp_id", 32'(rsp_id_log[r0+k]), 32'(exp_ord[k]));
        cmp("rr_rsp_prod", 32'(rsp_prod_log[r0+k]), 32'((exp_ord[k] + 1) * (exp_ord[k] + 2)));
      end
    end

    // backpressure: response held while requester 2 keeps asking
    do_reset(2);
    set_ops(2, 16'h0102, 9'h033);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    wait_grant(g);
    if (g < 0) fail_timeout("bp_grant");
    g = -1;
    for (int t = 0; t < 40 && g < 0; t++) begin
      step();
      if (s_rv) g = s_cyc;
    end
    if (g < 0) fail_timeout("bp_rsp");
    cap_p = s_prod;
    cap_id = s_id;
    cmp("bp_prod", 32'(cap_p), 32'h3366);
    bp_bad = 0;
    for (int t = 0; t < 50; t++) begin
      step();
      if (s_prod !== cap_p || s_id !== cap_id || s_rdy != '0 || !s_busy || !s_rv) bp_bad++;
    end
    cmp("bp_stable_cycles_bad", 32'(bp_bad), 32'(0));
    rsp_ready = 1'b1;
    step();
    step();
    cmp("bp_regrant_2", 32'(s_rdy), 32'(4'b0100));
    drain();

    // reset while waiting for the product, then pointer must be back at 0
    do_reset(2);
    set_ops(1, 16'h0007, 9'h009);
    req_valid = 4'b0010;
    wait_grant(g);
    req_valid = '0;
    if (g < 0) fail_timeout("rw_grant");
    for (int t = 0; t < 40 && cyc < g + 16; t++) step();
    RESET = 1'b1;
    step();
    RESET = 1'b0;
    step();
    cmp("rw_rsp_valid_after", 32'(s_rv), 32'(0));
    cmp("rw_busy_after", 32'(s_busy), 32'(0));
    set_ops(3, 16'h0011, 9'h003);
    req_valid = 4'b1010;
    wait_grant(g);
    cmp("rw_ptr_zero_grant", 32'(s_rdy), 32'(4'b0010));
    req_valid = '0;
    r0 = rsp_prod_log.size();
    drain();
    if (rsp_prod_log.size() == r0) fail_timeout("rw_followup");
    else cmp("rw_followup_prod", 32'(rsp_prod_log[r0]), 32'(63));

    // requester 3 withdraws while the controller is busy
    do_reset(2);
    r0 = rsp_id_log.size();
    set_ops(0, 16'h0005, 9'h006);
    req_valid = 4'b0001;
    wait_grant(g);
    req_valid = '0;
    repeat (4) step();
    set_ops(3, 16'h0100, 9'h002);
    req_valid = 4'b1000;
    repeat (6) step();
    req_valid = '0;
    drain();
    repeat (5) step();
    seen3 = 0;
    for (int k = r0; k < rsp_id_log.size(); k++) if (rsp_id_log[k] == 3) seen3 = 1;
    cmp("wd_no_rsp_id3", 32'(seen3), 32'(0));
    cmp("wd_rsp_count", 32'(rsp_id_log.size() - r0), 32'(1));

    // randomized traffic against the reference model
    gcount = 0;
    for (int t = 0; t < 4000; t++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (s_rdy[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          set_ops(i, ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
                     ($urandom_range(0, 3) == 0) ? 9'h1FF : 9'($urandom));
          req_valid[i] = 1'b1;
        end else if (req_valid[i] && $urandom_range(0, 40) == 0) begin
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      RESET = ($urandom_range(0, 799) == 0);
      step();
      if (s_rdy != '0) gcount++;
    end
    RESET = 1'b0;
    drain();
    n_cmp++;
    if (gcount < 50) begin
      n_bad++;
      $display("FAIL random_grants: got %0d expected at least 50", gcount);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mult_share_ctrl.md
Name: mult_share_ctrl

Overview:
Shares one seq16x9 sequential multiplier between NREQ requesters using round-robin arbitration.
- Per requester: captures operands on a valid/ready handshake and launches the multiplier by pulsing its reset.
- Waits a fixed MUL_LATENCY cycles, then returns the 25-bit product tagged with the requester id on a single valid/ready response port.
- Sits between client blocks and the seq16x9 instance. It is the only driver of the multiplier's RESET, in_Mx and in_My.

Parameters:
- NREQ, 4: number of requesters (2..8).
- MUL_LATENCY, 20: cycles from mul_rst deassertion to a valid Prod on the multiplier output (matched to seq16x9 sequencer).
- IDW, 2: id width, equal to clog2(NREQ).

Ports:
- CLK  in  1  clock.
- RESET  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant; one-hot or zero.
- req_mx  in  NREQ*16  packed multiplicands; requester i at [16i+15:16i].
- req_my  in  NREQ*9  packed multipliers; requester i at [9i+8:9i].
- rsp_valid  out  1  product valid.
- rsp_ready  in  1  consumer accepts product.
- rsp_prod  out  25  product Mx*My, unsigned.
- rsp_id  out  IDW  index of the requester that owns rsp_prod.
- mul_rst  out  1  drives seq16x9 RESET.
- mul_mx  out  16  drives seq16x9 in_Mx.
- mul_my  out  9  drives seq16x9 in_My.
- mul_prod  in  25  seq16x9 Prod.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Clocking and reset:
  - One clock, CLK.
  - Reset is synchronous and active-high on RESET.
  - All state registers update only on the rising edge of CLK.
- Reset values:
  - state=IDLE, rr_ptr=0, req_ready=0, rsp_valid=0, rsp_prod=0, rsp_id=0, mul_mx=0, mul_my=0, busy=0, counter=0.
  - mul_rst = RESET OR (state==LAUNCH). The multiplier is therefore held in reset whenever the controller is in reset.
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - Select the first i with req_valid[i]=1, searching from rr_ptr upward modulo NREQ.
  - If any is found, assert req_ready[i] combinationally in that cycle.
  - On the same edge: latch req_mx/req_my slice i into mul_mx/mul_my, latch grant id, set rr_ptr=(i+1) mod NREQ, go to LAUNCH.
  - If none is valid, stay in IDLE with req_ready=0.
- LAUNCH:
  - Exactly one cycle; mul_rst=1.
  - Load counter=MUL_LATENCY-1, go to WAIT.
- WAIT:
  - Decrement counter each cycle.
  - When counter==0: capture mul_prod into rsp_prod, drive rsp_id=grant id, set rsp_valid=1, go to RESP.
- RESP:
  - Hold rsp_valid, rsp_prod and rsp_id stable until rsp_ready=1.
  - On the handshake edge: rsp_valid=0, go to IDLE.
- Throughput: one operation in flight.
  - Minimum accept-to-accept spacing is MUL_LATENCY+3 cycles when rsp_ready is tied high.
  - Latency from request handshake to rsp_valid is MUL_LATENCY+1 cycles.
- Operand stability: mul_mx and mul_my stay constant from LAUNCH until the next grant. This satisfies the multiplier's need for stable inputs during its load states.
- Request protocol: a requester keeps req_valid and operands stable until req_ready. The controller samples operands only on the grant cycle. Dropping req_valid before grant is legal; that request is simply not served.
- req_ready is never asserted outside IDLE. Requests arriving in LAUNCH, WAIT or RESP wait.
- Arbitration:
  - Simultaneous requests are granted in rotating order.
  - No starvation: with all NREQ requesters valid, each is granted once every NREQ operations.
- Backpressure: an indefinitely low rsp_ready stalls in RESP; no new grants are made.
- Reset mid-operation: any state returns to IDLE on the next edge. An in-flight product is discarded and rsp_valid drops. The multiplier is held in reset through mul_rst.
- Arithmetic: rsp_prod is unsigned 16x9 with no truncation. The maximum result 0x1FEFE01 fits in 25 bits.

Decomposition:
- Shared package mult_share_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_LAUNCH=2'd1, ST_WAIT=2'd2, ST_RESP=2'd3.
  - widths MX_W=16, MY_W=9, PROD_W=25.
  - default MUL_LATENCY.
- One sub-module, rr_arbiter: takes req vector and rr_ptr, produces one-hot grant and grant index. Purely combinational.
- FSM, counter and datapath registers stay in mult_share_ctrl.

Test Plan:
- Single request: requester 1, Mx=0x1234, My=0x1FF → req_ready[1] pulses once; mul_rst high exactly 1 cycle; rsp_valid after MUL_LATENCY+1 cycles with rsp_prod=0x2455CC, rsp_id=1.
- Maximum operands: requester 0, Mx=0xFFFF, My=0x1FF → rsp_prod=0x1FEFE01. Also Mx=0, My=0x1FF → rsp_prod=0.
- All four requesters valid continuously, rr_ptr=0 after reset → grant order 0,1,2,3,0. Each rsp_id matches its own operand pair: Mx=i+1, My=i+2 gives products 2,6,12,20.
- Backpressure: hold rsp_ready=0 for 50 cycles with requester 2 valid → rsp_prod/rsp_id stable, req_ready stays 0, busy=1; raise rsp_ready → handshake, then grant to 2.
- Reset in WAIT: assert RESET 1 cycle at counter=5 → next cycle state IDLE, rsp_valid=0, mul_rst=1 during RESET, rr_ptr=0; a following request completes normally.
- Request withdrawn before grant during WAIT: requester 3 drops req_valid → no response with rsp_id=3 is ever produced.
